// File: rtl/ctrl_idex_hazard.sv
// ID/EX control register: decodes the ID instruction, inserts load-use bubbles, applies flushes.
// Define CTRL_MULDIV_EN to decode MULT/DIV/MFHI/MFLO and hold off HI/LO users while the unit is busy.
module ctrl_idex_hazard #(
  parameter int NB_OPCODE     = 6,
  parameter int NB_FUNCT      = 6,
  parameter int NB_REG        = 5,
  parameter int NB_CTRL_EX    = 10,
  parameter int NB_CTRL_M     = 9,
  parameter int NB_CTRL_WB    = 2,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [NB_OPCODE-1:0]  i_opcode,
  input  logic [NB_FUNCT-1:0]   i_funct,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic                  i_flush,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic [NB_REG-1:0]     o_ex_rt,
  output logic                  o_valid_ex,
  output logic                  o_illegal,
  output logic                  o_stall
);

  localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'(6'h00);
  localparam logic [NB_OPCODE-1:0] OP_J     = NB_OPCODE'(6'h02);
  localparam logic [NB_OPCODE-1:0] OP_JAL   = NB_OPCODE'(6'h03);
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'(6'h04);
  localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'(6'h05);
  localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'(6'h08);
  localparam logic [NB_OPCODE-1:0] OP_SLTI  = NB_OPCODE'(6'h0A);
  localparam logic [NB_OPCODE-1:0] OP_ANDI  = NB_OPCODE'(6'h0C);
  localparam logic [NB_OPCODE-1:0] OP_ORI   = NB_OPCODE'(6'h0D);
  localparam logic [NB_OPCODE-1:0] OP_XORI  = NB_OPCODE'(6'h0E);
  localparam logic [NB_OPCODE-1:0] OP_LUI   = NB_OPCODE'(6'h0F);
  localparam logic [NB_OPCODE-1:0] OP_LB    = NB_OPCODE'(6'h20);
  localparam logic [NB_OPCODE-1:0] OP_LH    = NB_OPCODE'(6'h21);
  localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'(6'h23);
  localparam logic [NB_OPCODE-1:0] OP_LBU   = NB_OPCODE'(6'h24);
  localparam logic [NB_OPCODE-1:0] OP_LHU   = NB_OPCODE'(6'h25);
  localparam logic [NB_OPCODE-1:0] OP_LWU   = NB_OPCODE'(6'h27);
  localparam logic [NB_OPCODE-1:0] OP_SB    = NB_OPCODE'(6'h28);
  localparam logic [NB_OPCODE-1:0] OP_SH    = NB_OPCODE'(6'h29);
  localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'(6'h2B);

  localparam logic [NB_FUNCT-1:0] F_SLL  = NB_FUNCT'(6'h00);
  localparam logic [NB_FUNCT-1:0] F_SRL  = NB_FUNCT'(6'h02);
  localparam logic [NB_FUNCT-1:0] F_SRA  = NB_FUNCT'(6'h03);
  localparam logic [NB_FUNCT-1:0] F_SLLV = NB_FUNCT'(6'h04);
  localparam logic [NB_FUNCT-1:0] F_SRLV = NB_FUNCT'(6'h06);
  localparam logic [NB_FUNCT-1:0] F_SRAV = NB_FUNCT'(6'h07);
  localparam logic [NB_FUNCT-1:0] F_JR   = NB_FUNCT'(6'h08);
  localparam logic [NB_FUNCT-1:0] F_JALR = NB_FUNCT'(6'h09);
  localparam logic [NB_FUNCT-1:0] F_ADD  = NB_FUNCT'(6'h20);
  localparam logic [NB_FUNCT-1:0] F_ADDU = NB_FUNCT'(6'h21);
  localparam logic [NB_FUNCT-1:0] F_SUB  = NB_FUNCT'(6'h22);
  localparam logic [NB_FUNCT-1:0] F_SUBU = NB_FUNCT'(6'h23);
  localparam logic [NB_FUNCT-1:0] F_AND  = NB_FUNCT'(6'h24);
  localparam logic [NB_FUNCT-1:0] F_OR   = NB_FUNCT'(6'h25);
  localparam logic [NB_FUNCT-1:0] F_XOR  = NB_FUNCT'(6'h26);
  localparam logic [NB_FUNCT-1:0] F_NOR  = NB_FUNCT'(6'h27);
  localparam logic [NB_FUNCT-1:0] F_SLT  = NB_FUNCT'(6'h2A);
  localparam logic [NB_FUNCT-1:0] F_SLTU = NB_FUNCT'(6'h2B);

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100, ALU_OR = 4'b0101, ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111, ALU_SLT = 4'b1000;

  if (MULDIV_CYCLES < 1) begin : g_cycles_check
    $error("MULDIV_CYCLES must be at least 1");
  end

  logic [9:0] dec_ex;
  logic [8:0] dec_mem;
  logic [1:0] dec_wb;
  logic       dec_illegal, dec_reads_rt;
  logic       load_use, md_stall, load_ok;

  logic [NB_CTRL_WB-1:0] wb_q, wb_d;
  logic [NB_CTRL_M-1:0]  mem_q, mem_d;
  logic [NB_CTRL_EX-1:0] ex_q, ex_d;
  logic [NB_REG-1:0]     rt_q, rt_d;
  logic                  valid_q, valid_d, illegal_q, illegal_d;

`ifdef CTRL_MULDIV_EN
  localparam logic [NB_FUNCT-1:0] F_MFHI  = NB_FUNCT'(6'h10);
  localparam logic [NB_FUNCT-1:0] F_MFLO  = NB_FUNCT'(6'h12);
  localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'h18);
  localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'h19);
  localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'h1A);
  localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'h1B);
  localparam logic [3:0]          ALU_MULDIV = 4'b0011;
  localparam int                  NB_CNT = $clog2(MULDIV_CYCLES + 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
  md_state_e         md_state_q, md_state_d;
  logic [NB_CNT-1:0] md_cnt_q, md_cnt_d;
  logic              dec_muldiv, dec_mfhilo, md_busy;
`endif

  always_comb begin
    dec_ex       = '0;
    dec_mem      = '0;
    dec_wb       = '0;
    dec_illegal  = 1'b0;
    dec_reads_rt = 1'b0;
`ifdef CTRL_MULDIV_EN
    dec_muldiv   = 1'b0;
    dec_mfhilo   = 1'b0;
`endif
    case (i_opcode)
      OP_RTYPE: begin
        dec_reads_rt = 1'b1;
        dec_ex       = {1'b1, 1'b0, ALU_RTYPE, 4'b0000};
        dec_wb       = 2'b10;
        case (i_funct)
          F_SLL, F_SRL, F_SRA: dec_ex[3] = 1'b1;
          F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: dec_ex[3] = 1'b0;
          F_JR: begin
            dec_ex[1] = 1'b1;
            dec_wb    = 2'b00;
          end
          F_JALR: dec_ex[1:0] = 2'b11;
`ifdef CTRL_MULDIV_EN
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            dec_ex[7:4] = ALU_MULDIV;
            dec_wb      = 2'b00;
            dec_muldiv  = 1'b1;
          end
          F_MFHI, F_MFLO: dec_mfhilo = 1'b1;
`endif
          default: begin
            dec_ex      = '0;
            dec_wb      = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      // opcode[1:0] gives the access size and opcode[2] the unsigned flag for loads and stores
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        dec_ex  = {2'b01, ALU_ADD, 4'b0000};
        dec_mem = {1'b1, 3'b000, i_opcode[1:0], i_opcode[2], 2'b00};
        dec_wb  = 2'b11;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_reads_rt = 1'b1;
        dec_ex       = {2'b01, ALU_ADD, 4'b0000};
        dec_mem      = {1'b0, 1'b1, 2'b00, i_opcode[1:0], 3'b000};
      end
      OP_ADDI: begin dec_ex = {2'b01, ALU_ADD, 4'b0000}; dec_wb = 2'b10; end
      OP_SLTI: begin dec_ex = {2'b01, ALU_SLT, 4'b0000}; dec_wb = 2'b10; end
      OP_ANDI: begin dec_ex = {2'b01, ALU_AND, 4'b0000}; dec_wb = 2'b10; end
      OP_ORI:  begin dec_ex = {2'b01, ALU_OR,  4'b0000}; dec_wb = 2'b10; end
      OP_XORI: begin dec_ex = {2'b01, ALU_XOR, 4'b0000}; dec_wb = 2'b10; end
      OP_LUI:  begin dec_ex = {2'b01, ALU_LUI, 4'b0000}; dec_wb = 2'b10; end
      OP_BEQ, OP_BNE: begin
        dec_reads_rt = 1'b1;
        dec_ex       = {2'b00, ALU_SUB, 4'b0000};
        dec_mem[6]   = (i_opcode == OP_BEQ);
        dec_mem[5]   = (i_opcode == OP_BNE);
      end
      OP_J:   dec_ex = {2'b00, ALU_ADD, 4'b0100};
      OP_JAL: begin dec_ex = {2'b00, ALU_ADD, 4'b0101}; dec_wb = 2'b10; end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign load_use = valid_q & mem_q[8] & (rt_q != '0) & i_valid &
                    ((rt_q == i_rs) | ((rt_q == i_rt) & dec_reads_rt));

`ifdef CTRL_MULDIV_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  // Only a mul/div that actually enters ID/EX starts the busy window
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: if (load_ok && dec_muldiv) begin
        md_state_d = MD_BUSY;
        md_cnt_d   = NB_CNT'(MULDIV_CYCLES);
      end
      MD_BUSY: if (md_cnt_q == NB_CNT'(1)) begin
        md_state_d = MD_IDLE;
        md_cnt_d   = '0;
      end else begin
        md_cnt_d = md_cnt_q - NB_CNT'(1);
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (md_state_q == MD_BUSY);
  end

  assign md_stall = md_busy & i_valid & (dec_muldiv | dec_mfhilo);
`else
  assign md_stall = 1'b0;
`endif

  assign load_ok = i_valid & ~i_flush & ~load_use & ~md_stall;
  assign o_stall = i_rst & ~i_flush & (load_use | md_stall);

  always_comb begin
    wb_d      = '0;
    mem_d     = '0;
    ex_d      = '0;
    rt_d      = '0;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    if (load_ok) begin
      wb_d      = NB_CTRL_WB'(dec_wb);
      mem_d     = NB_CTRL_M'(dec_mem);
      ex_d      = NB_CTRL_EX'(dec_ex);
      rt_d      = i_rt;
      valid_d   = 1'b1;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wb_q      <= '0;
      mem_q     <= '0;
      ex_q      <= '0;
      rt_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wb_q      <= wb_d;
      mem_q     <= mem_d;
      ex_q      <= ex_d;
      rt_q      <= rt_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ctrl_wb_bus  = wb_q;
  assign o_ctrl_mem_bus = mem_q;
  assign o_ctrl_exc_bus = ex_q;
  assign o_ex_rt        = rt_q;
  assign o_valid_ex     = valid_q;
  assign o_illegal      = illegal_q;

endmodule

// File: doc/ctrl_idex_hazard.md
Name: ctrl_idex_hazard

Overview:
- Pipelined successor of the combinational MIPS control decoder, with parametrised bus widths.
- Decodes the instruction in ID into EX/MEM/WB control buses and registers them as the control half of the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles; applies branch/jump flushes; flags illegal instructions.
- Sits between the IF/ID register and the execute stage; drives the PC/IF-ID hold signal.

Parameters:
- NB_OPCODE, 6, opcode width
- NB_FUNCT, 6, funct width
- NB_REG, 5, register specifier width
- NB_CTRL_EX, 10, EX control bus width
- NB_CTRL_M, 9, MEM control bus width
- NB_CTRL_WB, 2, WB control bus width
- MULDIV_CYCLES, 4, mul/div busy cycles (only used with the optional feature)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-low
- i_valid  in  1  ID holds a valid instruction
- i_opcode  in  NB_OPCODE  ID opcode
- i_funct  in  NB_FUNCT  ID funct
- i_rs  in  NB_REG  ID source register rs
- i_rt  in  NB_REG  ID source/target register rt
- i_flush  in  1  branch/jump taken, kill ID instruction
- o_ctrl_wb_bus  out  NB_CTRL_WB  registered WB controls
- o_ctrl_mem_bus  out  NB_CTRL_M  registered MEM controls
- o_ctrl_exc_bus  out  NB_CTRL_EX  registered EX controls
- o_ex_rt  out  NB_REG  registered rt of the EX-stage instruction
- o_valid_ex  out  1  EX stage holds a real instruction (not a bubble)
- o_illegal  out  1  registered: EX-stage instruction was undecodable
- o_stall  out  1  combinational: hold PC and IF/ID this cycle

Behaviour:
- Bus encodings:
  - EX: [9] reg_dst, [8] alu_src_imm, [7:4] alu_op, [3] shamt_src, [2] jump, [1] jump_reg, [0] link.
  - alu_op: 0010 R-type (funct decides), 0000 add, 0001 sub, 0100 and, 0101 or, 0110 xor, 0111 lui, 1000 slt.
  - MEM: [8] mem_read, [7] mem_write, [6] beq, [5] bne, [4:3] size (00 byte, 01 half, 11 word), [2] unsigned, [1:0] zero.
  - WB: [1] reg_write, [0] mem_to_reg.
- Decoded classes:
  - R-type, opcode 0: SLL/SRL/SRA (shamt_src=1), other ALU functs, JR (jump_reg, no reg_write), JALR (jump_reg, link, reg_write).
  - Loads: LB/LH/LW/LWU/LBU/LHU (mem_read, mem_to_reg, alu_src_imm, add).
  - Stores: SB/SH/SW (mem_write, alu_src_imm).
  - Immediate ALU: ADDI/ANDI/ORI/XORI/LUI/SLTI.
  - Branches: BEQ/BNE (sub).
  - Jumps: J, JAL (link, reg_write).
- Any other opcode, or an unlisted R-type funct, decodes to all-zero buses with illegal=1.
- Register update on each rising i_clk, priority high to low:
  1. Reset: all buses, o_ex_rt, o_valid_ex and o_illegal are 0; o_stall is 0 while reset is asserted. Reset mid-stall discards the stall.
  2. i_flush=1: load a bubble (all buses 0, o_valid_ex=0, o_illegal=0). o_stall is forced 0 that cycle.
  3. Load-use hazard: load a bubble and assert o_stall.
     - Hazard condition: o_valid_ex & o_ctrl_mem_bus[8] & o_ex_rt!=0 & i_valid & (o_ex_rt==i_rs | (o_ex_rt==i_rt & ID instruction reads rt)).
     - rt is read by R-type, stores and branches.
  4. i_valid=0: load a bubble, no stall.
  5. Otherwise: load the decoded buses, o_ex_rt=i_rt, o_valid_ex=1, o_illegal=decoded illegal.
- Latency: one cycle from ID to the registered buses. A load-use hazard costs exactly one stall cycle, because the bubble clears the hazard condition on the next cycle.
- Back-to-back loads into a dependent instruction still produce a single one-cycle stall.

Optional Feature:
- Macro CTRL_MULDIV_EN.
- When defined:
  - Functs MULT (011000), MULTU (011001), DIV (011010) and DIVU (011011) decode as R-type with alu_op 0011 and no reg_write.
  - MFHI (010000) and MFLO (010010) decode as R-type with reg_write.
  - An FSM with states IDLE and BUSY and a down-counter of clog2(MULDIV_CYCLES+1) bits. IDLE→BUSY (count=MULDIV_CYCLES) when a mul/div is actually loaded into ID/EX. Decrement each cycle; BUSY→IDLE when count reaches 1.
  - While BUSY, an MFHI/MFLO or mul/div in ID asserts o_stall and loads a bubble (same priority as a load-use hazard, below flush).
  - A flushed mul/div never starts the FSM. Reset returns the FSM to IDLE.
- When undefined: these functs are illegal and there is no FSM.

Test Plan:
- Hold i_rst=0, then release → all outputs 0. Next, opcode 100011 with i_valid=1 → next edge: mem bus 1_0_0_0_11_0_00, wb 11, exc alu_src_imm=1, alu_op 0000, o_valid_ex=1.
- LW rt=5, then ADD with rs=5 → o_stall=1 for exactly one cycle, bubble (o_valid_ex=0), then ADD decoded. Same sequence with rt=0 → no stall.
- LW rt=7, then SW with rt=7 → stall. LW rt=7, then ADDI with rt=7 (rt is a destination) → no stall.
- Hazard case with i_flush=1 in the same cycle → o_stall=0, bubble loaded, o_illegal=0.
- Opcode 111111 → o_illegal=1, all buses 0. R-type funct 111111 → o_illegal=1.
- With CTRL_MULDIV_EN and MULDIV_CYCLES=4: MULT, then MFLO immediately → MFLO stalls 4 cycles, then decodes with reg_write=1. Without the macro, MULT gives o_illegal=1.
